// File: rtl/uart_tx_cfg_if.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg_if
// Request/status bundle between a TX FIFO read side (master) and the
// configurable UART transmitter (slave).
//   tx_start     : request, qualified by tx_ready (FIFO rd)
//   din          : character, sampled at acceptance
//   cfg_dbits    : data bits 5..DATA_W (clamped by the transmitter)
//   cfg_parity   : 00 none, 01 even, 10 odd, 11 mark
//   cfg_stop     : 00 one, 01 one-and-half, 10/11 two
//   brk          : break request, holds the line low while idle
//   tx_ready     : transmitter can accept (FIFO ~empty side)
//   tx_done_tick : one-cycle pulse at frame end
// ---------------------------------------------------------------------------
interface uart_tx_cfg_if #(
    parameter int DATA_W = 8
);
    logic              tx_start;
    logic [DATA_W-1:0] din;
    logic [3:0]        cfg_dbits;
    logic [1:0]        cfg_parity;
    logic [1:0]        cfg_stop;
    logic              brk;
    logic              tx_ready;
    logic              tx_done_tick;

    modport master (
        output tx_start, din, cfg_dbits, cfg_parity, cfg_stop, brk,
        input  tx_ready, tx_done_tick
    );

    modport slave (
        input  tx_start, din, cfg_dbits, cfg_parity, cfg_stop, brk,
        output tx_ready, tx_done_tick
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
// Runtime-configurable UART transmitter. Sends one character per accepted
// request, LSB first, with programmable data length, parity and stop length.
// Bit timing comes from an external oversampling strobe (OVS per bit).
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   s_tick  : oversampling strobe, one clk wide
//   bus     : request/config/status bundle (uart_tx_cfg_if.slave)
//   tx      : serial line, registered, idle high
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
    parameter int DATA_W = 8,
    parameter int OVS    = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    uart_tx_cfg_if.slave    bus,
    output logic            tx
);
    localparam int S_W = $clog2(2 * OVS);
    localparam logic [S_W-1:0] S_BIT  = S_W'(OVS - 1);
    localparam logic [S_W-1:0] S_ONE5 = S_W'((3 * OVS) / 2 - 1);
    localparam logic [S_W-1:0] S_TWO  = S_W'(2 * OVS - 1);
    // cfg_dbits is 4 bits wide, so the usable maximum saturates at 15
    localparam logic [3:0]     D_MAX  = 4'((DATA_W > 15) ? 15 : DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t            state, state_n;
    logic [S_W-1:0]    s, s_n;
    logic [3:0]        n, n_n;
    logic [DATA_W-1:0] b, b_n;
    logic              par, par_n;        // running XOR of sent data bits
    logic [3:0]        dbits_q, dbits_n;
    logic [1:0]        parity_q, parity_n;
    logic [1:0]        stop_q, stop_n;
    logic              tx_n, rdy_q, rdy_n, done_q, done_n;
    logic [3:0]        dbits_in;
    logic [S_W-1:0]    stop_last;

    // Out-of-range lengths saturate instead of producing odd frames.
    always_comb begin
        dbits_in = bus.cfg_dbits;
        if (bus.cfg_dbits < 4'd5)
            dbits_in = 4'd5;
        else if (bus.cfg_dbits > D_MAX)
            dbits_in = D_MAX;
    end

    always_comb begin
        case (stop_q)
            2'b00:   stop_last = S_BIT;
            2'b01:   stop_last = S_ONE5;
            default: stop_last = S_TWO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            s        <= '0;
            n        <= '0;
            b        <= '0;
            par      <= 1'b0;
            dbits_q  <= '0;
            parity_q <= '0;
            stop_q   <= '0;
            tx       <= 1'b1;
            rdy_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            s        <= s_n;
            n        <= n_n;
            b        <= b_n;
            par      <= par_n;
            dbits_q  <= dbits_n;
            parity_q <= parity_n;
            stop_q   <= stop_n;
            tx       <= tx_n;
            rdy_q    <= rdy_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        s_n      = s;
        n_n      = n;
        b_n      = b;
        par_n    = par;
        dbits_n  = dbits_q;
        parity_n = parity_q;
        stop_n   = stop_q;
        done_n   = 1'b0;

        case (state)
            IDLE: begin
                // break has priority over a simultaneous request
                if (bus.brk) begin
                    state_n = BREAK;
                end else if (bus.tx_start) begin
                    b_n      = bus.din;
                    dbits_n  = dbits_in;
                    parity_n = bus.cfg_parity;
                    stop_n   = bus.cfg_stop;
                    s_n      = '0;
                    n_n      = '0;
                    par_n    = 1'b0;
                    state_n  = START;
                end
            end
            BREAK: begin
                if (!bus.brk)
                    state_n = IDLE;
            end
            START: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        s_n     = '0;
                        n_n     = '0;
                        state_n = DATA;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        s_n   = '0;
                        b_n   = {1'b0, b[DATA_W-1:1]};
                        par_n = par ^ b[0];
                        if (n == dbits_q - 4'd1)
                            state_n = (parity_q == 2'b00) ? STOP : PARITY;
                        else
                            n_n = n + 4'd1;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        s_n     = '0;
                        state_n = STOP;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == stop_last) begin
                        s_n     = '0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line and ready are registered from the next state so they switch on
    // the same edge as the state itself (e.g. 1->0 on the acceptance edge).
    always_comb begin
        tx_n  = 1'b1;
        rdy_n = 1'b0;
        case (state_n)
            IDLE:   rdy_n = 1'b1;
            BREAK:  tx_n  = 1'b0;
            START:  tx_n  = 1'b0;
            DATA:   tx_n  = b_n[0];
            PARITY: begin
                case (parity_n)
                    2'b01:   tx_n = par_n;
                    2'b10:   tx_n = ~par_n;
                    default: tx_n = 1'b1;
                endcase
            end
            default: tx_n = 1'b1;
        endcase
    end

    assign bus.tx_ready     = rdy_q;
    assign bus.tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg
// Directed bench for uart_tx_cfg: a table of frames with hand-derived bit
// sequences and tick counts, plus sequences for back-to-back, reset
// mid-frame, break and strobe gaps.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;
    localparam int DATA_W = 8;
    localparam int OVS    = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic s_tick  = 1'b0;
    logic tx;

    uart_tx_cfg_if #(.DATA_W(DATA_W)) bus();

    uart_tx_cfg #(.DATA_W(DATA_W), .OVS(OVS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_tick  (s_tick),
        .bus     (bus),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  din;
        logic [3:0]  dbits;
        logic [1:0]  par;
        logic [1:0]  stop;
        logic [15:0] bits;   // start, data, parity; index 0 sent first
        int          nbits;
        int          frame;  // total ticks including stop
    } vec_t;

    vec_t vecs [6];
    int   checks   = 0;
    int   failures = 0;
    int   ndone    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs from the cycle after acceptance until tx_done_tick is seen.
    // Optionally withholds s_tick for pause_len cycles once pause_at ticks
    // have been delivered.
    task automatic run_ticks(input string name, input logic [15:0] bits, input int nbits,
                             input int frame, input int pause_at, input int pause_len);
        int   ticks = 0;
        int   c = 0;
        int   paused = 0;
        int   budget;
        bit   done_seen = 0;
        bit   ready_bad = 0;
        bit   frz_bad = 0;
        logic held = 1'b0;
        logic expb;
        budget = 2 * frame + pause_len + 20;
        while (!done_seen && c < budget) begin
            c++;
            if (ticks == pause_at && paused < pause_len) begin
                s_tick = 1'b0;
                if (paused == 0) held = tx;
                else if (tx !== held) frz_bad = 1;
                paused++;
            end else begin
                s_tick = (c % 2 == 0);
            end
            if (s_tick) begin
                if (ticks % 8 == 4) begin
                    expb = (ticks < nbits * OVS) ? bits[ticks / OVS] : 1'b1;
                    chk($sformatf("%s tx@tick%0d", name, ticks), 32'(tx), 32'(expb));
                end
                ticks++;
            end
            step();
            if (bus.tx_done_tick) begin
                done_seen = 1;
                ndone++;
            end else if (bus.tx_ready) begin
                ready_bad = 1;
            end
        end
        s_tick = 1'b0;
        chk({name, " done_ticks"}, done_seen ? ticks : -1, frame);
        chk({name, " ready_low_in_frame"}, 32'(ready_bad), 0);
        chk({name, " ready_at_done"}, 32'(bus.tx_ready), 1);
        if (pause_len > 0)
            chk({name, " frozen_during_gap"}, 32'(frz_bad), 0);
    endtask

    task automatic send_frame(input int i, input int pause_at, input int pause_len);
        string nm;
        int    extra = 0;
        nm = $sformatf("v%0d", i);
        bus.din        = vecs[i].din;
        bus.cfg_dbits  = vecs[i].dbits;
        bus.cfg_parity = vecs[i].par;
        bus.cfg_stop   = vecs[i].stop;
        bus.tx_start   = 1'b1;
        s_tick = 1'b0;
        step();
        chk({nm, " accept_tx"}, 32'(tx), 0);
        chk({nm, " accept_ready"}, 32'(bus.tx_ready), 0);
        // scramble inputs: the frame in flight must not notice
        bus.tx_start   = 1'b0;
        bus.din        = ~vecs[i].din;
        bus.cfg_dbits  = 4'd6;
        bus.cfg_parity = ~vecs[i].par;
        bus.cfg_stop   = ~vecs[i].stop;
        run_ticks(nm, vecs[i].bits, vecs[i].nbits, vecs[i].frame, pause_at, pause_len);
        for (int k = 0; k < 6; k++) begin
            s_tick = (k % 2 == 0);
            step();
            if (bus.tx_done_tick) extra++;
        end
        s_tick = 1'b0;
        chk({nm, " single_done"}, extra, 0);
        chk({nm, " idle_tx"}, 32'(tx), 1);
    endtask

    initial begin
        int   base;
        int   t;
        int   c;
        bit   brk_bad;

        // din, dbits, parity, stop, bits (LSB sent first), nbits, frame ticks
        vecs[0] = '{8'hA5, 4'd8,  2'b00, 2'b00, 16'h014A, 9,  160}; // 8N1
        vecs[1] = '{8'hFF, 4'd7,  2'b01, 2'b10, 16'h01FE, 9,  176}; // 7E2
        vecs[2] = '{8'h03, 4'd5,  2'b10, 2'b01, 16'h0046, 7,  136}; // 5O1.5
        vecs[3] = '{8'h1E, 4'd2,  2'b11, 2'b10, 16'h007C, 7,  144}; // clamp->5, mark, 2
        vecs[4] = '{8'h3C, 4'd15, 2'b10, 2'b11, 16'h0278, 10, 192}; // clamp->8, odd, 2
        vecs[5] = '{8'hC7, 4'd6,  2'b01, 2'b00, 16'h008E, 8,  144}; // 6E1

        bus.tx_start   = 1'b0;
        bus.din        = '0;
        bus.cfg_dbits  = 4'd8;
        bus.cfg_parity = 2'b00;
        bus.cfg_stop   = 2'b00;
        bus.brk        = 1'b0;

        // reset state
        #13;
        chk("reset_tx", 32'(tx), 1);
        chk("reset_ready", 32'(bus.tx_ready), 1);
        chk("reset_done", 32'(bus.tx_done_tick), 0);
        reset_n = 1'b1;
        step();
        step();

        for (int i = 0; i < 6; i++)
            send_frame(i, -1, 0);

        // s_tick withheld mid-bit: line and counters hold, frame length unchanged
        send_frame(0, 20, 50);

        // back-to-back with tx_start held
        base = ndone;
        bus.din        = 8'h00;
        bus.cfg_dbits  = 4'd8;
        bus.cfg_parity = 2'b00;
        bus.cfg_stop   = 2'b00;
        bus.tx_start   = 1'b1;
        step();
        chk("b2b first_start", 32'(tx), 0);
        run_ticks("b2b0", 16'h0000, 9, 160, -1, 0);
        bus.din = 8'hFF;
        step();
        chk("b2b second_start_tx", 32'(tx), 0);
        chk("b2b second_start_ready", 32'(bus.tx_ready), 0);
        bus.tx_start = 1'b0;
        run_ticks("b2b1", 16'h01FE, 9, 160, -1, 0);
        chk("b2b done_pulses", ndone - base, 2);

        // reset during data bit 3 of 0xA5 (a 0 on the line)
        base = ndone;
        bus.din      = 8'hA5;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        t = 0;
        c = 0;
        while (t < 70 && c < 400) begin
            c++;
            s_tick = (c % 2 == 0);
            if (s_tick) t++;
            step();
            if (bus.tx_done_tick) ndone++;
        end
        s_tick = 1'b0;
        chk("rst_mid reached", t, 70);
        chk("rst_mid tx_before", 32'(tx), 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid tx", 32'(tx), 1);
        chk("rst_mid ready", 32'(bus.tx_ready), 1);
        for (int k = 0; k < 4; k++) begin
            s_tick = (k % 2 == 0);
            step();
            if (bus.tx_done_tick) ndone++;
        end
        s_tick  = 1'b0;
        reset_n = 1'b1;
        step();
        chk("rst_mid no_done", ndone - base, 0);
        send_frame(0, -1, 0);

        // break with a simultaneous request: break wins, request ignored
        base = ndone;
        bus.brk      = 1'b1;
        bus.tx_start = 1'b1;
        bus.din      = 8'h55;
        step();
        step();
        chk("brk tx_low", 32'(tx), 0);
        chk("brk ready_low", 32'(bus.tx_ready), 0);
        brk_bad = 0;
        for (int k = 0; k < 40; k++) begin
            s_tick = (k % 2 == 0);
            step();
            if (tx !== 1'b0 || bus.tx_done_tick) brk_bad = 1;
        end
        s_tick = 1'b0;
        chk("brk held_low", 32'(brk_bad), 0);
        bus.brk      = 1'b0;
        bus.tx_start = 1'b0;
        step();
        step();
        chk("brk release_tx", 32'(tx), 1);
        chk("brk release_ready", 32'(bus.tx_ready), 1);
        chk("brk no_done", ndone - base, 0);
        send_frame(2, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
